uart_frame_parser: RTL and testbench

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

---
 rtl/uart_frame_parser.sv | 121 ++++++++++++
 tb/tb_uart_frame_parser.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// Parses HEADER, 7 payload bytes, CTRL and an 8-bit additive checksum from a UART byte stream.
// A good frame updates rx_data/light; checksum failures and inter-byte timeouts pulse frame_err.
module uart_frame_parser #(
  parameter int unsigned CLK_FRE    = 50,
  parameter int unsigned TIMEOUT_US = 2000,
  parameter logic [7:0]  HEADER     = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic [55:0] rx_data,
  output logic        light,
  output logic        frame_done,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  localparam int unsigned LIMIT = (CLK_FRE * TIMEOUT_US == 0) ? 1 : CLK_FRE * TIMEOUT_US;
  localparam int unsigned TW    = $clog2(LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CTRL,
    CHECK
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q;
  logic [7:0]    sum_q;
  logic [TW-1:0] tmo_q;
  logic [55:0]   shadow_q;
  logic [7:0]    ctrl_q;

  logic start, shift_en, ctrl_en, good, bad, expire;

  // A byte arriving in the expiry cycle suppresses the timeout.
  assign expire = (state_q != IDLE) && !byte_valid && (tmo_q == TW'(LIMIT - 1));

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    shift_en = 1'b0;
    ctrl_en  = 1'b0;
    good     = 1'b0;
    bad      = 1'b0;
    if (expire) begin
      state_d = IDLE;
      bad     = 1'b1;
    end else if (byte_valid) begin
      case (state_q)
        IDLE: begin
          if (byte_data == HEADER) begin
            start   = 1'b1;
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          shift_en = 1'b1;
          if (idx_q == 3'd6) state_d = CTRL;
        end
        CTRL: begin
          ctrl_en = 1'b1;
          state_d = CHECK;
        end
        CHECK: begin
          state_d = IDLE;
          if (byte_data == sum_q) good = 1'b1;
          else                    bad  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      sum_q      <= '0;
      tmo_q      <= '0;
      shadow_q   <= '0;
      ctrl_q     <= '0;
      rx_data    <= '0;
      light      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      frame_done <= good;
      frame_err  <= bad;

      if (bad && (err_cnt != '1)) err_cnt <= err_cnt + 8'd1;

      if (byte_valid || (state_q == IDLE) || expire) tmo_q <= '0;
      else                                           tmo_q <= tmo_q + TW'(1);

      if (start || expire) begin
        idx_q    <= '0;
        sum_q    <= '0;
        shadow_q <= '0;
        ctrl_q   <= '0;
      end else if (shift_en) begin
        shadow_q <= {shadow_q[47:0], byte_data};
        idx_q    <= idx_q + 3'd1;
        sum_q    <= sum_q + byte_data;
      end else if (ctrl_en) begin
        ctrl_q <= byte_data;
        sum_q  <= sum_q + byte_data;
      end

      if (good) begin
        rx_data <= shadow_q;
        light   <= ctrl_q[0];
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: fixed frame table, hand-built corner sequences and random
// streams checked every cycle against a byte-queue frame model.
module tb_uart_frame_parser;

  localparam int unsigned CLK_FRE_T    = 1;
  localparam int unsigned TIMEOUT_US_T = 20;
  localparam int unsigned LIMIT        = CLK_FRE_T * TIMEOUT_US_T;
  localparam logic [7:0]  HDR          = 8'hA5;

  logic        clk;
  logic        rst_n;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic [55:0] rx_data;
  logic        light;
  logic        frame_done;
  logic        frame_err;
  logic [7:0]  err_cnt;

  uart_frame_parser #(
    .CLK_FRE   (CLK_FRE_T),
    .TIMEOUT_US(TIMEOUT_US_T),
    .HEADER    (HDR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .rx_data   (rx_data),
    .light     (light),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes collected since the header, idle cycles since the last byte.
  bit          m_in_frame;
  logic [7:0]  m_q[$];
  int unsigned m_idle;
  logic [55:0] exp_rx;
  logic        exp_light;
  logic        exp_done;
  logic        exp_err;
  int unsigned exp_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_frame = 0;
    m_q.delete();
    m_idle    = 0;
    exp_rx    = '0;
    exp_light = 1'b0;
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    exp_cnt   = 0;
  endtask

  task automatic model_cycle(input bit v, input logic [7:0] d);
    int unsigned s;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (v) begin
      m_idle = 0;
      if (!m_in_frame) begin
        if (d == HDR) begin
          m_in_frame = 1;
          m_q.delete();
        end
      end else begin
        m_q.push_back(d);
        if (m_q.size() == 9) begin
          s = 0;
          for (int i = 0; i < 8; i++) s += m_q[i];
          if ((s % 256) == m_q[8]) begin
            exp_done = 1'b1;
            exp_rx   = '0;
            for (int i = 0; i < 7; i++) exp_rx = {exp_rx[47:0], m_q[i]};
            exp_light = m_q[7][0];
          end else begin
            exp_err = 1'b1;
          end
          m_in_frame = 0;
        end
      end
    end else if (m_in_frame) begin
      m_idle++;
      if (m_idle == LIMIT) begin
        exp_err    = 1'b1;
        m_in_frame = 0;
        m_q.delete();
      end
    end
    if (exp_err && exp_cnt < 255) exp_cnt++;
  endtask

  task automatic compare_all();
    chk("rx_data", rx_data, exp_rx);
    chk("light", light, exp_light);
    chk("frame_done", frame_done, exp_done);
    chk("frame_err", frame_err, exp_err);
    chk("err_cnt", err_cnt, exp_cnt);
  endtask

  task automatic step(input bit v, input logic [7:0] d);
    byte_valid = v;
    byte_data  = d;
    @(posedge clk);
    model_cycle(v, d);
    #1;
    compare_all();
    byte_valid = 1'b0;
  endtask

  task automatic reset_step();
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    compare_all();
    rst_n = 1'b1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  typedef struct {
    string       name;
    int unsigned n;
    logic [7:0]  b[12];
    logic [55:0] rx;
    logic        lt;
    logic        done;
    logic        err;
  } vec_t;

  vec_t        tbl[5];
  logic [7:0]  fb[9];
  int unsigned s, gap, pulses, nnoise;
  logic [7:0]  cnt_before;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0].name = "good";     tbl[0].n = 10;
    tbl[0].b = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h01, 8'h1D, 8'h00, 8'h00};
    tbl[0].rx = 56'h01020304050607; tbl[0].lt = 1'b1; tbl[0].done = 1'b1; tbl[0].err = 1'b0;
    tbl[1].name = "badsum";   tbl[1].n = 10;
    tbl[1].b = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h01, 8'h1C, 8'h00, 8'h00};
    tbl[1].rx = 56'h01020304050607; tbl[1].lt = 1'b1; tbl[1].done = 1'b0; tbl[1].err = 1'b1;
    tbl[2].name = "inband";   tbl[2].n = 12;
    tbl[2].b = '{8'h00, 8'hFF, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h83};
    tbl[2].rx = 56'hA5A5A5A5A5A5A5; tbl[2].lt = 1'b0; tbl[2].done = 1'b1; tbl[2].err = 1'b0;
    tbl[3].name = "wrapsum";  tbl[3].n = 10;
    tbl[3].b = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'hFC, 8'h00, 8'h00};
    tbl[3].rx = 56'hFFFFFFFFFFFFFF; tbl[3].lt = 1'b1; tbl[3].done = 1'b1; tbl[3].err = 1'b0;
    tbl[4].name = "hdrctrl";  tbl[4].n = 10;
    tbl[4].b = '{8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'hA5, 8'h65, 8'h00, 8'h00};
    tbl[4].rx = 56'h10203040506070; tbl[4].lt = 1'b1; tbl[4].done = 1'b1; tbl[4].err = 1'b0;

    rst_n      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    model_reset();
    reset_step();
    reset_step();
    step(1'b0, 8'h00);

    // Table of complete frames sent back to back.
    for (int t = 0; t < 5; t++) begin
      for (int unsigned i = 0; i < tbl[t].n; i++) step(1'b1, tbl[t].b[i]);
      chk({tbl[t].name, "_done"}, frame_done, tbl[t].done);
      chk({tbl[t].name, "_err"}, frame_err, tbl[t].err);
      chk({tbl[t].name, "_rx"}, rx_data, tbl[t].rx);
      chk({tbl[t].name, "_light"}, light, tbl[t].lt);
      step(1'b0, 8'h00);
      chk({tbl[t].name, "_pulse_end"}, {frame_done, frame_err}, 2'b00);
    end
    chk("table_err_cnt", err_cnt, 8'd1);

    // Timeout mid-frame, then a good frame.
    cnt_before = err_cnt;
    step(1'b1, 8'hA5); step(1'b1, 8'h11); step(1'b1, 8'h22);
    pulses = 0;
    for (int unsigned i = 0; i < LIMIT + 5; i++) begin
      step(1'b0, 8'h00);
      if (frame_err) pulses++;
    end
    chk("timeout_pulses", pulses, 1);
    chk("timeout_err_cnt", err_cnt, cnt_before + 8'd1);
    for (int unsigned i = 0; i < 10; i++) step(1'b1, tbl[0].b[i]);
    chk("after_timeout_done", frame_done, 1'b1);
    chk("after_timeout_rx", rx_data, 56'h01020304050607);

    // Bytes arriving exactly in the expiry cycle keep the frame alive.
    fb = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h00, 8'h6C};
    step(1'b1, 8'hA5);
    for (int i = 0; i < 9; i++) begin
      idle(LIMIT - 1);
      step(1'b1, fb[i]);
    end
    chk("edge_gap_done", frame_done, 1'b1);
    chk("edge_gap_rx", rx_data, 56'h31323334353637);
    chk("edge_gap_light", light, 1'b0);

    // Reset in the middle of a frame.
    step(1'b1, 8'hA5); step(1'b1, 8'h01); step(1'b1, 8'h02);
    reset_step();
    chk("rst_rx", rx_data, 56'h0);
    chk("rst_cnt", err_cnt, 8'h00);
    pulses = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      step(1'b1, tbl[0].b[i]);
      if (frame_err) pulses++;
    end
    chk("rst_then_good_done", frame_done, 1'b1);
    chk("rst_then_good_rx", rx_data, 56'h01020304050607);
    chk("rst_no_err", pulses, 0);

    // Random streams with noise, corrupted sums and occasional long gaps.
    for (int f = 0; f < 150; f++) begin
      nnoise = $urandom_range(0, 2);
      for (int unsigned i = 0; i < nnoise; i++) step(1'b1, 8'($urandom_range(0, 255)));
      step(1'b1, HDR);
      s = 0;
      for (int i = 0; i < 8; i++) begin
        fb[i] = 8'($urandom_range(0, 255));
        s += fb[i];
      end
      fb[8] = 8'(s);
      if ($urandom_range(0, 3) == 0) fb[8] = fb[8] ^ 8'($urandom_range(1, 255));
      for (int i = 0; i < 9; i++) begin
        if ($urandom_range(0, 19) == 0) gap = ($urandom_range(0, 1) != 0) ? LIMIT - 1 : LIMIT + 1;
        else gap = $urandom_range(0, 2);
        idle(gap);
        step(1'b1, fb[i]);
      end
      idle($urandom_range(0, 3));
    end

    // Saturate the error counter with continuous bad frames.
    reset_step();
    for (int f = 0; f < 260; f++)
      for (int unsigned i = 0; i < 10; i++) step(1'b1, tbl[1].b[i]);
    chk("sat_cnt", err_cnt, 8'hFF);
    for (int unsigned i = 0; i < 10; i++) step(1'b1, tbl[4].b[i]);
    chk("sat_good_done", frame_done, 1'b1);
    chk("sat_good_rx", rx_data, 56'h10203040506070);
    chk("sat_cnt_hold", err_cnt, 8'hFF);
    step(1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
